// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM state type, default frame width and round-robin pick
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_GAP
  } spi_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int MAX_REQ    = 8;

  // First set bit searching upward from last+1, wrapping at n; -1 when nothing is set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
    int c;
    rr_pick = -1;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        c = (last + k) % n;
        if (req[c]) rr_pick = c;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: request vector and last grant in,
// one-hot grant and grant index out
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_valid
);

  logic [MAX_REQ-1:0] w_req_ext;
  int                 w_pick;

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
  end

  assign w_pick      = rr_pick(w_req_ext, int'(i_last), NUM_REQ);
  assign o_valid     = |i_req;
  assign o_grant_idx = IDX_W'(w_pick);

  always_comb begin
    o_grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant_oh[i] = o_valid && (o_grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sequencer sharing one SPI engine between NUM_REQ clients
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_data,
  input  logic                      eng_done,
  output logic [NUM_REQ-1:0]        spi_cs_l,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  spi_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_last_grant, w_last_nxt;
  logic [DATA_W-1:0]   r_eng_data, w_data_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic [NUM_REQ-1:0]  r_cs_l, w_cs_nxt;
  logic                r_start, w_start_nxt;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_nxt;

  logic [NUM_REQ-1:0]  w_arb_oh;
  logic [IDX_W-1:0]    w_arb_idx;
  logic                w_arb_valid;
  logic [DATA_W-1:0]   w_sel_data;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0]     r_wd_cnt, w_wd_nxt;
  logic                r_timeout, w_to_nxt;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req       (req_valid),
    .i_last      (r_last_grant),
    .o_grant_oh  (w_arb_oh),
    .o_grant_idx (w_arb_idx),
    .o_valid     (w_arb_valid)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == IDX_W'(i)) w_sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // All outputs are registered: each state's action becomes visible one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_data_nxt  = r_eng_data;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_start_nxt = 1'b0;
    w_cs_nxt    = r_cs_l;
    w_gap_nxt   = r_gap_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
    w_wd_nxt    = r_wd_cnt;
    w_to_nxt    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt = w_arb_idx;
          w_data_nxt  = w_sel_data;
          w_ack_nxt   = w_arb_oh;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_cs_nxt          = '1;
        w_cs_nxt[r_grant] = 1'b0;
        w_start_nxt       = 1'b1;
        w_state_nxt       = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        w_wd_nxt          = '0;
`endif
      end
      ST_WAIT: begin
        if (eng_done) begin
          w_done_nxt[r_grant] = 1'b1;
          w_cs_nxt            = '1;
          w_last_nxt          = r_grant;
          w_gap_nxt           = GAP_W'(GAP_CYCLES - 1);
          w_state_nxt         = ST_GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          w_done_nxt[r_grant] = 1'b1;
          w_to_nxt            = 1'b1;
          w_cs_nxt            = '1;
          w_last_nxt          = r_grant;
          w_gap_nxt           = GAP_W'(GAP_CYCLES - 1);
          w_state_nxt         = ST_GAP;
        end else begin
          w_wd_nxt = r_wd_cnt + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
        else                 w_gap_nxt   = r_gap_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_eng_data   <= '0;
      r_ack        <= '0;
      r_done       <= '0;
      r_cs_l       <= '1;
      r_start      <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_eng_data   <= w_data_nxt;
      r_ack        <= w_ack_nxt;
      r_done       <= w_done_nxt;
      r_cs_l       <= w_cs_nxt;
      r_start      <= w_start_nxt;
      r_gap_cnt    <= w_gap_nxt;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_nxt;
      r_timeout <= w_to_nxt;
    end
  end
  assign timeout_err = r_timeout;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ack   = r_ack;
  assign req_done  = r_done;
  assign eng_start = r_start;
  assign eng_data  = r_eng_data;
  assign spi_cs_l  = r_cs_l;
  assign busy      = (r_state != ST_IDLE);

endmodule
